// File: rtl/cmd_uart_bridge_if.sv
// Bundle of UART-side and command-side signals of the command/UART bridge.
// Latency: none (wires only).
// Backpressure: carried by rx_rdy/clr_rx_rdy and cmd_rdy/clr_cmd_rdy pairs.
//
// master : the bridge itself (drives clr_rx_rdy, cmd, cmd_rdy, trmt, tx_data, resp_sent)
// slave  : the surrounding UART + command processor (drives the remaining signals)
interface cmd_uart_bridge_if;
  logic        rx_rdy;       // UART receiver holds an unread byte
  logic [7:0]  rx_data;      // received byte, valid while rx_rdy
  logic        clr_rx_rdy;   // byte consumed this cycle
  logic [15:0] cmd;          // assembled command
  logic        cmd_rdy;      // command waiting for the consumer
  logic        clr_cmd_rdy;  // consumer has taken cmd
  logic        send_resp;    // request one acknowledge byte
  logic        trmt;         // start a UART transmit
  logic [7:0]  tx_data;      // byte to transmit
  logic        tx_done;      // UART transmit finished
  logic        resp_sent;    // one response completed

  modport master (
    input  rx_rdy, rx_data, clr_cmd_rdy, send_resp, tx_done,
    output clr_rx_rdy, cmd, cmd_rdy, trmt, tx_data, resp_sent
  );

  modport slave (
    output rx_rdy, rx_data, clr_cmd_rdy, send_resp, tx_done,
    input  clr_rx_rdy, cmd, cmd_rdy, trmt, tx_data, resp_sent
  );
endinterface

// File: rtl/cmd_uart_bridge.sv
// Assembles two UART bytes (high first) into a 16-bit command; sends one ack byte per response request.
// Latency: cmd/cmd_rdy one edge after the low byte; trmt one edge after send_resp; resp_sent one edge after tx_done.
// Backpressure: a pending command (cmd_rdy=1) stalls the receiver; at most one response request is queued.
//
// Ports: clk, rst (async, active-high); bus = cmd_uart_bridge_if.master carrying
//   rx_rdy/rx_data/clr_rx_rdy, cmd/cmd_rdy/clr_cmd_rdy, send_resp/trmt/tx_data/tx_done/resp_sent.
module cmd_uart_bridge #(
  parameter int          TMO_CYCLES = 1_000_000,  // must be >= 2
  parameter logic [7:0]  RESP_BYTE  = 8'hA5
) (
  input  logic               clk,
  input  logic               rst,
  cmd_uart_bridge_if.master  bus
);

  localparam int TW = (TMO_CYCLES > 2) ? $clog2(TMO_CYCLES) : 1;
  // Timer value seen in the last cycle a low byte may still arrive; the
  // increment out of this cycle reaches TMO_CYCLES-1 and ends the wait.
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYCLES - 2);

  localparam logic [0:0] WAIT_HIGH = 1'b0;
  localparam logic [0:0] WAIT_LOW  = 1'b1;
  localparam logic [0:0] TX_IDLE   = 1'b0;
  localparam logic [0:0] TX_BUSY   = 1'b1;

  logic [0:0]    rx_state_q, rx_state_d;
  logic [7:0]    high_q, high_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [15:0]   cmd_q, cmd_d;
  logic          cmd_rdy_q, cmd_rdy_d;
  logic          rx_take;

  logic [0:0]    tx_state_q, tx_state_d;
  logic          pending_q, pending_d;
  logic          trmt_q, trmt_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          resp_sent_q, resp_sent_d;

  // Receive side
  always_comb begin
    rx_state_d = rx_state_q;
    high_d     = high_q;
    timer_d    = timer_q;
    cmd_d      = cmd_q;
    cmd_rdy_d  = cmd_rdy_q;
    rx_take    = 1'b0;

    if (bus.clr_cmd_rdy) cmd_rdy_d = 1'b0;

    if (rx_state_q == WAIT_HIGH) begin
      // A command still waiting for its consumer blocks the next one.
      if (bus.rx_rdy && !cmd_rdy_q) begin
        rx_take    = 1'b1;
        high_d     = bus.rx_data;
        timer_d    = '0;
        rx_state_d = WAIT_LOW;
      end
    end else begin
      if (bus.rx_rdy) begin
        // A byte arriving in the expiry cycle still completes the command.
        rx_take    = 1'b1;
        cmd_d      = {high_q, bus.rx_data};
        cmd_rdy_d  = 1'b1;
        rx_state_d = WAIT_HIGH;
      end else begin
        if (timer_q != '1) timer_d = timer_q + 1'b1;
        if (timer_q == TMO_LAST) rx_state_d = WAIT_HIGH;
      end
    end
  end

  // Transmit side
  always_comb begin
    tx_state_d  = tx_state_q;
    pending_d   = pending_q;
    trmt_d      = 1'b0;
    tx_data_d   = tx_data_q;
    resp_sent_d = 1'b0;

    if (tx_state_q == TX_IDLE) begin
      if (bus.send_resp) begin
        trmt_d     = 1'b1;
        tx_data_d  = RESP_BYTE;
        tx_state_d = TX_BUSY;
      end
    end else begin
      if (bus.tx_done) begin
        resp_sent_d = 1'b1;
        // A request coinciding with tx_done is queued and served at once,
        // exactly like one queued earlier; tx_data already holds RESP_BYTE.
        if (pending_q || bus.send_resp) begin
          pending_d = 1'b0;
          trmt_d    = 1'b1;
        end else begin
          tx_state_d = TX_IDLE;
        end
      end else if (bus.send_resp) begin
        pending_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_q  <= WAIT_HIGH;
      high_q      <= '0;
      timer_q     <= '0;
      cmd_q       <= '0;
      cmd_rdy_q   <= 1'b0;
      tx_state_q  <= TX_IDLE;
      pending_q   <= 1'b0;
      trmt_q      <= 1'b0;
      tx_data_q   <= '0;
      resp_sent_q <= 1'b0;
    end else begin
      rx_state_q  <= rx_state_d;
      high_q      <= high_d;
      timer_q     <= timer_d;
      cmd_q       <= cmd_d;
      cmd_rdy_q   <= cmd_rdy_d;
      tx_state_q  <= tx_state_d;
      pending_q   <= pending_d;
      trmt_q      <= trmt_d;
      tx_data_q   <= tx_data_d;
      resp_sent_q <= resp_sent_d;
    end
  end

  // Gated by rst so the reset state never acknowledges a byte.
  assign bus.clr_rx_rdy = rx_take & ~rst;
  assign bus.cmd        = cmd_q;
  assign bus.cmd_rdy    = cmd_rdy_q;
  assign bus.trmt       = trmt_q;
  assign bus.tx_data    = tx_data_q;
  assign bus.resp_sent  = resp_sent_q;

endmodule

// File: tb/tb_cmd_uart_bridge.sv
module tb_cmd_uart_bridge;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   trmt_cnt;
  int   resp_cnt;
  int   t0;
  int   r0;

  cmd_uart_bridge_if bus();

  cmd_uart_bridge #(
    .TMO_CYCLES (16),
    .RESP_BYTE  (8'hA5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle.
  initial begin
    trmt_cnt = 0;
    resp_cnt = 0;
  end
  always @(negedge clk) begin
    if (bus.trmt === 1'b1) trmt_cnt++;
    if (bus.resp_sent === 1'b1) resp_cnt++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one byte for one cycle; it must be consumed in that cycle.
  task automatic send_byte(input logic [7:0] b);
    bus.rx_rdy  = 1'b1;
    bus.rx_data = b;
    #1;
    chk("clr_rx_rdy_on_byte", 16'(bus.clr_rx_rdy), 16'h1);
    tick();
    bus.rx_rdy = 1'b0;
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    bus.rx_rdy      = 1'b0;
    bus.rx_data     = 8'h00;
    bus.clr_cmd_rdy = 1'b0;
    bus.send_resp   = 1'b0;
    bus.tx_done     = 1'b0;
    rst             = 1'b0;
    #1 rst = 1'b1;
    bus.rx_rdy  = 1'b1;
    bus.rx_data = 8'h99;
    #10;
    chk("rst_cmd",        bus.cmd, 16'h0000);
    chk("rst_cmd_rdy",    16'(bus.cmd_rdy), 16'h0);
    chk("rst_trmt",       16'(bus.trmt), 16'h0);
    chk("rst_tx_data",    16'(bus.tx_data), 16'h0);
    chk("rst_resp_sent",  16'(bus.resp_sent), 16'h0);
    chk("rst_clr_rx_rdy", 16'(bus.clr_rx_rdy), 16'h0);
    tick();
    rst        = 1'b0;
    bus.rx_rdy = 1'b0;
    tick();

    // Basic assembly 0x20, 0x7F
    send_byte(8'h20);
    chk("cmd_rdy_after_high", 16'(bus.cmd_rdy), 16'h0);
    send_byte(8'h7F);
    chk("cmd_207f", bus.cmd, 16'h207F);
    chk("cmd_rdy_set", 16'(bus.cmd_rdy), 16'h1);
    bus.clr_cmd_rdy = 1'b1;
    tick();
    bus.clr_cmd_rdy = 1'b0;
    chk("cmd_rdy_cleared", 16'(bus.cmd_rdy), 16'h0);
    chk("cmd_held_after_clr", bus.cmd, 16'h207F);

    // Backpressure while cmd_rdy=1
    send_byte(8'h60);
    send_byte(8'h00);
    chk("cmd_6000", bus.cmd, 16'h6000);
    bus.rx_rdy  = 1'b1;
    bus.rx_data = 8'h20;
    #1;
    chk("bp_no_clr", 16'(bus.clr_rx_rdy), 16'h0);
    tick();
    tick();
    tick();
    chk("bp_no_clr_later", 16'(bus.clr_rx_rdy), 16'h0);
    chk("bp_cmd_stable", bus.cmd, 16'h6000);
    bus.clr_cmd_rdy = 1'b1;
    #1;
    chk("bp_no_clr_during_clr_cmd", 16'(bus.clr_rx_rdy), 16'h0);
    tick();
    bus.clr_cmd_rdy = 1'b0;
    #1;
    chk("bp_accept_after_clr", 16'(bus.clr_rx_rdy), 16'h1);
    chk("bp_cmd_rdy_low", 16'(bus.cmd_rdy), 16'h0);
    tick();
    bus.rx_rdy = 1'b0;
    send_byte(8'h11);
    chk("cmd_2011", bus.cmd, 16'h2011);
    chk("cmd_rdy_2011", 16'(bus.cmd_rdy), 16'h1);
    bus.clr_cmd_rdy = 1'b1;
    tick();
    bus.clr_cmd_rdy = 1'b0;

    // Low byte in the expiry cycle (cycle 15) still completes
    send_byte(8'h12);
    repeat (14) tick();
    send_byte(8'h34);
    chk("cmd_expiry_cycle_1234", bus.cmd, 16'h1234);
    chk("cmd_rdy_expiry_cycle", 16'(bus.cmd_rdy), 16'h1);
    bus.clr_cmd_rdy = 1'b1;
    tick();
    bus.clr_cmd_rdy = 1'b0;

    // Timeout: 0x40 dropped, back in WAIT_HIGH at cycle 16
    send_byte(8'h40);
    repeat (15) tick();
    send_byte(8'h41);
    chk("tmo_41_is_high", 16'(bus.cmd_rdy), 16'h0);
    send_byte(8'h02);
    chk("cmd_4102", bus.cmd, 16'h4102);
    chk("cmd_rdy_4102", 16'(bus.cmd_rdy), 16'h1);
    bus.clr_cmd_rdy = 1'b1;
    tick();
    bus.clr_cmd_rdy = 1'b0;

    // Single response
    bus.send_resp = 1'b1;
    tick();
    bus.send_resp = 1'b0;
    chk("trmt_pulse", 16'(bus.trmt), 16'h1);
    chk("tx_data_a5", 16'(bus.tx_data), 16'h00A5);
    tick();
    chk("trmt_one_cycle", 16'(bus.trmt), 16'h0);
    repeat (8) tick();
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    chk("resp_sent_pulse", 16'(bus.resp_sent), 16'h1);
    chk("no_trmt_after_done", 16'(bus.trmt), 16'h0);
    tick();
    chk("resp_sent_one_cycle", 16'(bus.resp_sent), 16'h0);
    chk("tx_data_held", 16'(bus.tx_data), 16'h00A5);

    // Three requests while busy -> one extra transmit
    t0 = trmt_cnt;
    r0 = resp_cnt;
    bus.send_resp = 1'b1;
    tick();
    bus.send_resp = 1'b0;
    chk("trmt_busy_start", 16'(bus.trmt), 16'h1);
    repeat (3) begin
      bus.send_resp = 1'b1;
      tick();
      bus.send_resp = 1'b0;
      tick();
    end
    chk("no_trmt_while_busy", 16'(bus.trmt), 16'h0);
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    chk("pend_resp_sent", 16'(bus.resp_sent), 16'h1);
    chk("pend_reissue_trmt", 16'(bus.trmt), 16'h1);
    tick();
    chk("pend_trmt_one_cycle", 16'(bus.trmt), 16'h0);
    repeat (5) tick();
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    chk("pend_resp_sent_2", 16'(bus.resp_sent), 16'h1);
    chk("pend_no_third_trmt", 16'(bus.trmt), 16'h0);
    repeat (4) tick();
    chk("pend_trmt_count", 16'(trmt_cnt - t0), 16'd2);
    chk("pend_resp_count", 16'(resp_cnt - r0), 16'd2);

    // send_resp coinciding with tx_done is queued and re-issued
    bus.send_resp = 1'b1;
    tick();
    bus.send_resp = 1'b0;
    tick();
    bus.send_resp = 1'b1;
    bus.tx_done   = 1'b1;
    tick();
    bus.send_resp = 1'b0;
    bus.tx_done   = 1'b0;
    chk("coinc_resp_sent", 16'(bus.resp_sent), 16'h1);
    chk("coinc_trmt", 16'(bus.trmt), 16'h1);
    tick();
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    chk("coinc_resp_sent_2", 16'(bus.resp_sent), 16'h1);
    chk("coinc_no_more_trmt", 16'(bus.trmt), 16'h0);
    tick();

    // Reset mid-command and mid-transmit
    send_byte(8'h55);
    bus.send_resp = 1'b1;
    tick();
    bus.send_resp = 1'b1;
    tick();
    bus.send_resp = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_cmd",       bus.cmd, 16'h0000);
    chk("mid_rst_cmd_rdy",   16'(bus.cmd_rdy), 16'h0);
    chk("mid_rst_trmt",      16'(bus.trmt), 16'h0);
    chk("mid_rst_tx_data",   16'(bus.tx_data), 16'h0);
    chk("mid_rst_resp_sent", 16'(bus.resp_sent), 16'h0);
    tick();
    rst         = 1'b0;
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    chk("post_rst_no_resp", 16'(bus.resp_sent), 16'h0);
    chk("post_rst_no_trmt", 16'(bus.trmt), 16'h0);
    send_byte(8'h00);
    chk("post_rst_high_only", 16'(bus.cmd_rdy), 16'h0);
    send_byte(8'h00);
    chk("post_rst_cmd_0000", bus.cmd, 16'h0000);
    chk("post_rst_cmd_rdy", 16'(bus.cmd_rdy), 16'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
